// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer with debounced run/pause and mode buttons
module led_sequencer_button #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          s;
    logic          deb;
    logic          deb_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            s     <= sync1;
            deb_d <= deb;
            // Only the released-to-pressed edge of the debounced level is an event
            press <= deb_d & ~deb;
            if (s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module led_sequencer #(
    parameter int LED_WIDTH       = 6,
    parameter int TICK_DIV        = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_run_n,
    input  logic                 btn_mode_n,
    output logic [LED_WIDTH-1:0] led,
    output logic                 running,
    output logic [1:0]           mode,
    output logic                 tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic                 run_press;
    logic                 mode_press;
    logic [PW-1:0]        presc;
    logic [LED_WIDTH-1:0] pattern;
    logic [LED_WIDTH-1:0] pattern_step;
    logic [LED_WIDTH-1:0] start_value;
    logic                 dir;
    logic                 dir_step;
    logic                 step;
    logic [1:0]           mode_next;

    led_sequencer_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_run_n),
        .press (run_press)
    );

    led_sequencer_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode_n),
        .press (mode_press)
    );

    assign step        = running && (presc == PRE_MAX);
    assign mode_next   = mode + 2'd1;
    // Ring and bounce modes start one-hot at bit 0; counters start at zero
    assign start_value = mode_next[1] ? LED_WIDTH'(1) : '0;

    always_comb begin
        pattern_step = pattern;
        dir_step     = dir;
        case (mode)
            2'd0: pattern_step = pattern + LED_WIDTH'(1);
            2'd1: pattern_step = pattern - LED_WIDTH'(1);
            2'd2: pattern_step = {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
            default: begin
                if (!dir) begin
                    if (pattern[LED_WIDTH-1]) begin
                        pattern_step = pattern >> 1;
                        dir_step     = 1'b1;
                    end else begin
                        pattern_step = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        pattern_step = pattern << 1;
                        dir_step     = 1'b0;
                    end else begin
                        pattern_step = pattern >> 1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= '0;
            mode    <= 2'd0;
            running <= 1'b1;
            presc   <= '0;
            tick    <= 1'b0;
            dir     <= 1'b0;
        end else begin
            tick <= step;
            if (run_press) begin
                running <= ~running;
            end
            // A mode press restarts the pattern and overrides a coincident step
            if (mode_press) begin
                mode    <= mode_next;
                presc   <= '0;
                dir     <= 1'b0;
                pattern <= start_value;
            end else begin
                if (running) begin
                    presc <= step ? '0 : presc + PW'(1);
                end
                if (step) begin
                    pattern <= pattern_step;
                    dir     <= dir_step;
                end
            end
        end
    end

    assign led = (LED_ACTIVE_LOW != 0) ? ~pattern : pattern;
endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer
module tb_led_sequencer;
    logic       clk;
    logic       rst;
    logic       btn_run_n;
    logic       btn_mode_n;
    logic [5:0] led;
    logic       running;
    logic [1:0] mode;
    logic       tick;
    logic [5:0] pat;

    int total = 0;
    int bad   = 0;
    int n;
    int ticks;

    logic [5:0] seq2 [6]  = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1};
    logic [5:0] seq3 [11] = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1, 6'd2};

    led_sequencer #(
        .LED_WIDTH       (6),
        .TICK_DIV        (5),
        .DEBOUNCE_CYCLES (4),
        .LED_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run_n  (btn_run_n),
        .btn_mode_n (btn_mode_n),
        .led        (led),
        .running    (running),
        .mode       (mode),
        .tick       (tick)
    );

    assign pat = ~led;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tick !== 1'b1 && cnt < 40);
        total++;
        assert (tick === 1'b1) else begin
            bad++;
            $error("FAIL %s: observed=no tick after %0d cycles expected=tick", tag, cnt);
        end
    endtask

    task automatic press_mode();
        btn_mode_n = 1'b0;
        cyc(8);
        btn_mode_n = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        btn_run_n  = 1'b1;
        btn_mode_n = 1'b1;
        cyc(3);
        rst = 1'b0;
        check("rst_led", led, 6'h3F);
        check("rst_running", running, 1);
        check("rst_mode", mode, 0);
        check("rst_tick", tick, 0);

        cyc(4);
        check("tick_early", tick, 0);
        cyc(1);
        check("tick_first", tick, 1);
        check("tick_first_pat", pat, 1);
        cyc(1);
        check("tick_pulse", tick, 0);
        cyc(4);
        check("tick_period", tick, 1);
        check("tick_period_pat", pat, 2);
        cyc(5 * 61);
        check("count_63_tick", tick, 1);
        check("count_63", pat, 63);
        cyc(5);
        check("wrap_tick", tick, 1);
        check("wrap_zero", pat, 0);

        // short glitch on the run button
        btn_run_n = 1'b0;
        cyc(3);
        btn_run_n = 1'b1;
        cyc(1);
        wait_tick("glitch_tick", n);
        cyc(5);
        check("glitch_running", running, 1);
        check("glitch_pat", pat, 2);

        // held run press: toggles 7 edges after first capture
        btn_run_n = 1'b0;
        cyc(7);
        check("run_lat_early", running, 1);
        cyc(1);
        check("run_lat", running, 0);
        check("run_lat_pat", pat, 3);
        btn_run_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_pat", pat, 3);

        btn_run_n = 1'b0;
        cyc(8);
        check("resume_running", running, 1);
        cyc(1);
        check("resume_no_tick", tick, 0);
        cyc(1);
        check("resume_tick", tick, 1);
        check("resume_pat", pat, 4);
        btn_run_n = 1'b1;
        cyc(4);
        check("resume_period_early", tick, 0);
        cyc(1);
        check("resume_period", tick, 1);
        check("resume_period_pat", pat, 5);

        // mode 1: binary down
        press_mode();
        check("mode1", mode, 1);
        check("mode1_load", pat, 0);
        wait_tick("mode1_t1", n);
        check("mode1_t1_n", n, 5);
        check("mode1_t1_pat", pat, 63);
        wait_tick("mode1_t2", n);
        check("mode1_t2_pat", pat, 62);

        // mode 2: ring
        press_mode();
        check("mode2", mode, 2);
        check("mode2_load", pat, 1);
        for (int i = 0; i < 6; i++) begin
            wait_tick("mode2_tick", n);
            check("mode2_n", n, 5);
            check("mode2_pat", pat, seq2[i]);
        end

        // mode 3: bounce
        press_mode();
        check("mode3", mode, 3);
        check("mode3_load", pat, 1);
        for (int i = 0; i < 11; i++) begin
            wait_tick("mode3_tick", n);
            check("mode3_pat", pat, seq3[i]);
        end

        press_mode();
        check("mode0", mode, 0);
        check("mode0_load", pat, 0);

        // mode press landing on a tick edge
        wait_tick("coll_align", n);
        check("coll_align_pat", pat, 1);
        cyc(2);
        press_mode();
        check("coll_mode", mode, 1);
        check("coll_mode_pat", pat, 0);
        wait_tick("coll_mode_next", n);
        check("coll_mode_next_n", n, 5);
        check("coll_mode_next_pat", pat, 63);

        // run press landing on a tick edge
        cyc(2);
        btn_run_n = 1'b0;
        cyc(8);
        check("coll_run_running", running, 0);
        check("coll_run_tick", tick, 1);
        check("coll_run_pat", pat, 61);
        btn_run_n = 1'b1;
        cyc(10);
        check("coll_run_hold", pat, 61);
        btn_run_n = 1'b0;
        cyc(8);
        btn_run_n = 1'b1;
        check("coll_run_resume", running, 1);

        // reset in mid-bounce with the mode button held
        press_mode();
        cyc(10);
        press_mode();
        check("rst2_mode3", mode, 3);
        for (int i = 0; i < 6; i++) wait_tick("rst2_bounce", n);
        check("rst2_mid_bounce", pat, 16);
        btn_mode_n = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        check("rst2_led", led, 6'h3F);
        check("rst2_mode", mode, 0);
        check("rst2_running", running, 1);
        check("rst2_tick", tick, 0);
        rst = 1'b0;
        cyc(7);
        check("held_early_mode", mode, 0);
        check("held_early_pat", pat, 1);
        cyc(1);
        check("held_mode", mode, 1);
        check("held_pat", pat, 0);
        btn_mode_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for the FPGA test boards: a prescaled step tick drives a pattern register shown on the board LEDs. Two debounced push-buttons toggle run/pause and advance the pattern mode. The mode press also restarts the pattern. Top-level block sitting directly between the board clock/buttons and the LED pins.

## Interface
- LED_WIDTH, 6, number of LEDs/pattern bits; legal range is 2 or more
- TICK_DIV, 13500000, clock cycles per pattern step; legal range is 1 or more
- DEBOUNCE_CYCLES, 270000, consecutive stable synchronised samples needed to accept a button level; legal range is 1 or more
- LED_ACTIVE_LOW, 1, 1 means `led` is the inverted pattern, 0 means `led` equals the pattern
- clk  in  1  board clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- btn_run_n  in  1  raw asynchronous button, active-low; each press toggles run/pause
- btn_mode_n  in  1  raw asynchronous button, active-low; each press advances mode and restarts the pattern
- led  out  LED_WIDTH  LED drive
- running  out  1  1 = stepping, 0 = paused
- mode  out  2  current mode
- tick  out  1  one-cycle pulse on each step

## Operation
- **Button path (per button):**
  - 2-FF synchroniser, reset to 1, gives sample `s`.
  - Debounced level `deb` resets to 1 (released).
  - Counter `cnt` resets to 0. `cnt` increments while `s != deb` and clears when `s == deb`.
  - When `cnt == DEBOUNCE_CYCLES-1` and `s != deb`: `deb <= s` and `cnt <= 0`.
  - Press event is a registered one-cycle pulse, set on a `deb` 1->0 transition. Releases generate no event.
- **Prescaler:** counts 0..TICK_DIV-1 only while `running`, and holds while paused. At TICK_DIV-1 it wraps to 0 and `tick` is registered high for one cycle. The pattern advances on the edge that registers `tick`.
- **Modes and step rules:**
  - 0 binary up: P+1, modulo 2^LED_WIDTH; wraps all-ones -> 0.
  - 1 binary down: P-1, modulo 2^LED_WIDTH; wraps 0 -> all-ones.
  - 2 ring: rotate left by 1; bit LED_WIDTH-1 returns to bit 0.
  - 3 bounce: one-hot ping-pong using an internal direction bit `dir` (0 = left).
    - At bit LED_WIDTH-1 moving left, reverse and step to bit LED_WIDTH-2.
    - At bit 0 moving right, reverse and step to bit 1.
    - Period is 2*(LED_WIDTH-1) ticks.
- **Run press:** `running <= ~running`.
- **Mode press:**
  - `mode <= mode+1`, wrapping 3 -> 0.
  - Prescaler <= 0 and `dir <= 0`.
  - Pattern loads the new mode's start value: 0 for modes 0/1, 1 (bit 0) for modes 2/3.
- `led = LED_ACTIVE_LOW ? ~pattern : pattern`, combinational from the pattern register.
- **Reset values (rst high on an edge, all registers):**
  - pattern=0, mode=0, running=1, prescaler=0, tick=0, dir=0.
  - Synchronisers/deb=1, cnt=0, press pulses=0.
  - `led` = all-ones when LED_ACTIVE_LOW=1.
  - Reset mid-debounce or mid-count discards all progress. A button still held at reset release must be seen stable low for the full DEBOUNCE_CYCLES before it produces an event.

## Timing
- **Button latency:** raw low first captured at edge E0 gives `deb` low at edge E0+DEBOUNCE_CYCLES+1, press pulse high at edge E0+DEBOUNCE_CYCLES+2, and the resulting state change at edge E0+DEBOUNCE_CYCLES+3.
- **Glitches:** any return of `s` to `deb` before the count completes clears `cnt`; no event is generated.
- **Tick period:** exactly TICK_DIV cycles while running. The first tick after reset is high in the cycle following edge TICK_DIV, and the pattern changes on that same edge.
- **Pause mid-count:** the prescaler value is held; on resume it continues from the held value with no extra or lost cycles.
- **Simultaneous events:**
  - Run press on the same edge as a tick advance: the advance occurs, and `running` toggles on the same edge.
  - Mode press on the same edge as a tick advance: mode press wins; the start value is loaded and no advance occurs.
  - Both presses on the same edge: both take effect, giving a new mode, start value and toggled `running`.
- **TICK_DIV=1:** `tick` is continuously high while running, and the pattern advances every cycle.

## Test plan
Bench parameters: LED_WIDTH=6, TICK_DIV=5, DEBOUNCE_CYCLES=4, LED_ACTIVE_LOW=1.
- **Reset/count:** release rst -> `led`=6'b111111, running=1, mode=0; `tick` every 5 cycles; after 64 ticks pattern wraps 63 -> 0.
- **Debounce:**
  - `btn_run_n` low for 3 cycles then high -> no toggle.
  - `btn_run_n` held low -> running=0 exactly DEBOUNCE_CYCLES+3 = 7 edges after first capture.
  - While paused, pattern and prescaler are frozen for 100 cycles.
  - Second press -> stepping resumes with the period unchanged.
- **Modes:**
  - One mode press -> mode=1, pattern 0 -> 63 -> 62 on successive ticks.
  - Press again -> mode=2, pattern 1,2,4,...,32,1.
  - Press again -> mode=3, pattern 1,2,4,8,16,32,16,8,4,2,1, period 10.
  - Press again -> mode=0, pattern=0.
- **Collisions:**
  - Force the mode press pulse on a tick edge -> start value loaded, no advance.
  - Force the run press on a tick edge -> advance occurs and running=0.
- **Reset mid-operation:** assert rst in mode 3 mid-bounce with `btn_mode_n` held low -> all reset values restored. After release, still-held button -> mode=1 only after 4 stable samples.
